// File: rtl/dmem_resp.sv
// Data-memory responder: word-organised RAM serving word/half/byte loads and stores
// with a fixed access latency and a one-cycle ready/err pulse. Optional DMEM_MISALIGN_CHECK_EN.
module dmem_resp #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int unsigned LAT       = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        dmem_r,
  input  logic        dmem_w,
  input  logic [1:0]  store_format_signal,
  input  logic [31:0] data_addr,
  input  logic [31:0] w_data,
  output logic [31:0] dmem_data,
  output logic        dmem_ready,
  output logic        dmem_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    fmt_q, fmt_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;

  logic [31:0]   mem_q [DEPTH];

  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          is_half, is_byte, is_word;
  logic          oor, misalign, acc_err;
  logic [31:0]   word_rd, load_val, wlane;
  logic [3:0]    be;
  logic          complete, mem_we;

  always_comb begin
    offset   = addr_q - BASE_ADDR;
    idx      = offset[AW+1:2];
    oor      = |offset[31:AW+2];
    is_half  = (fmt_q == 2'b01);
    is_byte  = (fmt_q == 2'b10);
    is_word  = !is_half && !is_byte;
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign = (is_half && offset[0]) || (is_word && (offset[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    acc_err  = oor || misalign;
    word_rd  = mem_q[idx];
  end

  // Without the misalign check, low offset bits below the access size are simply ignored.
  always_comb begin
    load_val = word_rd;
    be       = 4'hF;
    wlane    = wdata_q;
    if (is_half) begin
      load_val = {16'h0000, offset[1] ? word_rd[31:16] : word_rd[15:0]};
      be       = offset[1] ? 4'b1100 : 4'b0011;
      wlane    = {2{wdata_q[15:0]}};
    end else if (is_byte) begin
      load_val = {24'h00_0000, word_rd[8*offset[1:0] +: 8]};
      be       = 4'b0001 << offset[1:0];
      wlane    = {4{wdata_q[7:0]}};
    end
  end

  assign complete = (state_q == S_BUSY) && (cnt_q == '0);
  assign mem_we   = complete && we_q && !acc_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    fmt_d   = fmt_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dmem_r || dmem_w) begin
          addr_d  = data_addr;
          fmt_d   = store_format_signal;
          wdata_d = w_data;
          we_d    = dmem_w;
          cnt_d   = CNT_INIT;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          ready_d = 1'b1;
          err_d   = acc_err;
          if (acc_err) begin
            rdata_d = '0;
          end else if (!we_q) begin
            rdata_d = load_val;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      fmt_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      fmt_q   <= fmt_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset; writes only happen on a completing BUSY edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  assign dmem_data  = rdata_q;
  assign dmem_ready = ready_q;
  assign dmem_err   = err_q;

endmodule
